// File: rtl/button_event_scheduler_if.sv
// Event handshake bundle between the button scheduler and its consumer.
// The scheduler drives the master side; the consumer uses the slave side.
interface button_event_scheduler_if;
    logic       event_valid;
    logic       event_ready;
    logic [2:0] event_id;
    logic       event_type;
    logic       overflow;

    modport master (
        output event_valid,
        output event_id,
        output event_type,
        output overflow,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_id,
        input  event_type,
        input  overflow,
        output event_ready
    );
endinterface

// File: rtl/button_event_scheduler.sv
// Five-button press/auto-repeat event generator sharing one sample tick,
// with per-button pending flags drained by a round-robin valid/ready arbiter.
module button_event_scheduler #(
    parameter int TICK_COUNT   = 12_499_999,
    parameter int HOLD_TICKS   = 4,
    parameter int REPEAT_TICKS = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [4:0]                btn_in,
    button_event_scheduler_if.master  evt
);

    localparam int NB = 5;
    localparam int CW = (TICK_COUNT > 0) ? $clog2(TICK_COUNT + 1) : 1;
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam logic [CW-1:0] TICK_LAST   = CW'(TICK_COUNT);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_TICKS - REPEAT_TICKS);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic [NB-1:0]   samp;
    logic [HW-1:0]   hold_cnt [NB];
    logic [NB-1:0]   press_req, rep_req;
    logic [NB-1:0]   pend_press, pend_rep;
    logic [NB-1:0]   clr_press, clr_rep;
    logic [2:0]      rr_ptr;
    logic [3:0]      rr_sum;
    logic [2:0]      rr_idx;
    logic            grant;
    logic [2:0]      grant_id;
    logic            grant_type;
    logic            valid_q, type_q, ovf_q;
    logic [2:0]      id_q;

    assign tick = (tick_cnt == TICK_LAST);

    // NOTE: every register is written with <= so all flops sample the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + CW'(1);
    end

    // NOTE: defaults first in every always_comb, otherwise a missed branch infers a latch.
    always_comb begin
        press_req = '0;
        rep_req   = '0;
        for (int i = 0; i < NB; i++) begin
            press_req[i] = tick & btn_in[i] & ~samp[i];
            rep_req[i]   = tick & btn_in[i] & samp[i] & (hold_cnt[i] == HOLD_LAST);
        end
    end

    // NOTE: the hold counters are a handful of flops, not a RAM, so resetting them is free.
    always_ff @(posedge clock) begin
        if (reset) begin
            samp <= '0;
            for (int i = 0; i < NB; i++) hold_cnt[i] <= '0;
        end else if (tick) begin
            samp <= btn_in;
            for (int i = 0; i < NB; i++) begin
                if (press_req[i] || !btn_in[i]) hold_cnt[i] <= '0;
                else if (rep_req[i])            hold_cnt[i] <= HOLD_RELOAD;
                else                            hold_cnt[i] <= hold_cnt[i] + HW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Round-robin search from the button after the last grant; press beats repeat.
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_id   = '0;
        grant_type = 1'b0;
        clr_press  = '0;
        clr_rep    = '0;
        rr_sum     = '0;
        rr_idx     = '0;
        case (state)
            IDLE: begin
                for (int k = 1; k <= NB; k++) begin
                    rr_sum = {1'b0, rr_ptr} + 4'(k);
                    if (rr_sum >= 4'd5) rr_sum = rr_sum - 4'd5;
                    rr_idx = rr_sum[2:0];
                    if (!grant && (pend_press[rr_idx] || pend_rep[rr_idx])) begin
                        grant     = 1'b1;
                        grant_id  = rr_idx;
                        state_nxt = PRESENT;
                        if (pend_press[rr_idx]) begin
                            clr_press[rr_idx] = 1'b1;
                        end else begin
                            clr_rep[rr_idx] = 1'b1;
                            grant_type      = 1'b1;
                        end
                    end
                end
            end
            PRESENT: if (evt.event_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A request landing on a bit granted this cycle is not lost, so it is no overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_press <= '0;
            pend_rep   <= '0;
            rr_ptr     <= 3'd4;
            valid_q    <= 1'b0;
            id_q       <= '0;
            type_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | press_req;
            pend_rep   <= (pend_rep & ~clr_rep) | rep_req;
            ovf_q      <= |((press_req & pend_press & ~clr_press) |
                            (rep_req & pend_rep & ~clr_rep));
            valid_q    <= (state_nxt == PRESENT);
            if (grant) begin
                rr_ptr <= grant_id;
                id_q   <= grant_id;
                type_q <= grant_type;
            end
        end
    end

    assign evt.event_valid = valid_q;
    assign evt.event_id    = id_q;
    assign evt.event_type  = type_q;
    assign evt.overflow    = ovf_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Bench for button_event_scheduler: directed scenarios plus random stimulus,
// every cycle compared against a tick-level behavioural model.
module tb_button_event_scheduler;

  localparam int TICK_COUNT   = 3;
  localparam int HOLD_TICKS   = 4;
  localparam int REPEAT_TICKS = 1;
  localparam int NB           = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] btn_in;

  button_event_scheduler_if bus ();

  button_event_scheduler #(
    .TICK_COUNT  (TICK_COUNT),
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .btn_in(btn_in),
    .evt   (bus.master)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int dut_events;
  int ovf_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cycles since reset give the tick; held ticks give repeats.
  int m_cyc;
  bit m_prev [NB];
  int m_held [NB];
  bit m_pp   [NB];
  bit m_pr   [NB];
  int m_last;
  bit m_busy;
  int m_id;
  bit m_type;
  bit m_ovf;

  task automatic model_edge(input bit rst, input logic [4:0] b, input bit rdy);
    bit preq [NB];
    bit rreq [NB];
    bit gp   [NB];
    bit gr   [NB];
    bit tick;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_prev[i] = 0; m_held[i] = 0; m_pp[i] = 0; m_pr[i] = 0;
      end
      m_cyc = 0; m_last = 4; m_busy = 0; m_id = 0; m_type = 0; m_ovf = 0;
      return;
    end
    tick = ((m_cyc % (TICK_COUNT + 1)) == TICK_COUNT);
    for (int i = 0; i < NB; i++) begin
      preq[i] = 0; rreq[i] = 0; gp[i] = 0; gr[i] = 0;
      if (tick) begin
        if (b[i] && !m_prev[i]) begin
          preq[i]   = 1;
          m_held[i] = 0;
        end else if (b[i]) begin
          m_held[i]++;
          if (m_held[i] >= HOLD_TICKS && ((m_held[i] - HOLD_TICKS) % REPEAT_TICKS) == 0)
            rreq[i] = 1;
        end else begin
          m_held[i] = 0;
        end
        m_prev[i] = b[i];
      end
    end
    if (!m_busy) begin
      for (int k = 1; k <= NB; k++) begin
        int j;
        j = (m_last + k) % NB;
        if (m_pp[j] || m_pr[j]) begin
          if (m_pp[j]) begin gp[j] = 1; m_type = 0; end
          else         begin gr[j] = 1; m_type = 1; end
          m_id = j; m_last = j; m_busy = 1;
          break;
        end
      end
    end else if (rdy) begin
      m_busy = 0;
    end
    m_ovf = 0;
    for (int i = 0; i < NB; i++) begin
      if ((preq[i] && m_pp[i] && !gp[i]) || (rreq[i] && m_pr[i] && !gr[i])) m_ovf = 1;
      m_pp[i] = (m_pp[i] && !gp[i]) || preq[i];
      m_pr[i] = (m_pr[i] && !gr[i]) || rreq[i];
    end
    m_cyc++;
  endtask

  task automatic cycle(input bit rst, input logic [4:0] b, input bit rdy);
    reset           = rst;
    btn_in          = b;
    bus.event_ready = rdy;
    if (bus.event_valid && rdy && !rst) dut_events++;
    @(posedge clock);
    model_edge(rst, b, rdy);
    #1;
    check("event_valid", 32'(bus.event_valid), 32'(m_busy));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (m_busy || rst) begin
      check("event_id", 32'(bus.event_id), 32'(m_id));
      check("event_type", 32'(bus.event_type), 32'(m_type));
    end
    if (bus.overflow) ovf_seen++;
  endtask

  task automatic run(input int n, input logic [4:0] b, input bit rdy);
    for (int c = 0; c < n; c++) cycle(1'b0, b, rdy);
  endtask

  task automatic wait_valid(input logic [4:0] b, input string tag);
    int c = 0;
    while (!bus.event_valid && c < 20) begin
      cycle(1'b0, b, 1'b1);
      c++;
    end
    check(tag, 32'(bus.event_valid), 32'd1);
  endtask

  initial begin
    logic [4:0] b;
    bit         r;
    reset = 1'b1; btn_in = '0; bus.event_ready = 1'b0;
    dut_events = 0; ovf_seen = 0;

    for (int c = 0; c < 3; c++) cycle(1'b1, 5'b0, 1'b0);

    // Single press on button 0.
    dut_events = 0;
    run(8, 5'b00001, 1'b1);
    run(12, 5'b00000, 1'b1);
    check("single_press_count", 32'(dut_events), 32'd1);

    // Button 2 held for six ticks: press plus two repeats.
    dut_events = 0;
    run(24, 5'b00100, 1'b1);
    run(16, 5'b00000, 1'b1);
    check("hold_repeat_count", 32'(dut_events), 32'd3);

    // All buttons together, twice.
    for (int round = 0; round < 2; round++) begin
      dut_events = 0;
      run(8, 5'b11111, 1'b1);
      run(16, 5'b00000, 1'b1);
      check("all_buttons_count", 32'(dut_events), 32'd5);
    end

    // Stalled consumer: second press pends, third overflows.
    dut_events = 0; ovf_seen = 0;
    for (int p = 0; p < 5; p++) run(4, (p % 2 == 0) ? 5'b00010 : 5'b00000, 1'b0);
    check("stall_overflow_pulses", 32'(ovf_seen), 32'd1);
    run(16, 5'b00000, 1'b1);
    check("stall_delivered", 32'(dut_events), 32'd2);

    // Reset while presenting, button released: nothing afterwards.
    wait_valid(5'b00001, "wait_valid_released");
    cycle(1'b1, 5'b00000, 1'b1);
    dut_events = 0;
    run(16, 5'b00000, 1'b1);
    check("reset_drop_count", 32'(dut_events), 32'd0);

    // Reset while presenting, button still held: one fresh press.
    wait_valid(5'b01000, "wait_valid_held");
    cycle(1'b1, 5'b01000, 1'b1);
    dut_events = 0;
    run(10, 5'b01000, 1'b1);
    run(12, 5'b00000, 1'b1);
    check("reset_held_count", 32'(dut_events), 32'd1);

    // Random buttons, consumer back-pressure and occasional reset.
    b = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(15) == 0) b[i] = ~b[i];
      r = ($urandom_range(499) == 0);
      cycle(r, b, ($urandom_range(3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
